// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Owner/state encodings and port indices for mem_port_arbiter.
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

    // The owner output and the arbiter state share this encoding.
    localparam logic [1:0] OWN_FREE = 2'b00;
    localparam logic [1:0] OWN_R0   = 2'b01;
    localparam logic [1:0] OWN_R1   = 2'b10;

    localparam int PORT_R0 = 0;
    localparam int PORT_R1 = 1;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick2
// Brief   : Two-way round-robin chooser; on a tie the port not granted last wins.
// Revision: 1.0
// ============================================================================
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Round-robin, lockable two-port arbiter in front of a single-port RAM.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo,
    output logic [1:0]    owner,
    output logic [31:0]   conflict_cnt
);

    localparam int             LCW         = $clog2(MAX_LOCK);
    localparam logic [LCW-1:0] c_lock_last = LCW'(MAX_LOCK - 1);

    logic [1:0]     r_state, w_state_nxt;
    logic           r_last_gnt, w_last_nxt;
    logic [LCW-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic [1:0]     w_pick, w_gnt;
    logic           w_lock_sel, w_conflict;
    logic           w_rd0, w_rd1;
    logic           r_rvalid0, r_rvalid1;
    logic [DW-1:0]  r_rdata0, r_rdata1;
    logic [31:0]    r_conflict_cnt;

    rr_pick2 u_pick (
        .i_req  ({r1_req, r0_req}),
        .i_last (r_last_gnt),
        .o_gnt  (w_pick)
    );

    // Grants are combinational; nothing is granted while reset is held.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (r_state)
                OWN_FREE: w_gnt = w_pick;
                OWN_R0:   w_gnt = {1'b0, r0_req};
                OWN_R1:   w_gnt = {r1_req, 1'b0};
                default:  w_gnt = 2'b00;
            endcase
        end
    end

    assign w_lock_sel = w_gnt[PORT_R1] ? r1_lock : r0_lock;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_last_nxt     = r_last_gnt;
        if (|w_gnt) begin
            w_last_nxt = w_gnt[PORT_R1];
            // The last allowed locked cycle forces a release regardless of lock.
            if (w_lock_sel && (r_lock_cnt != c_lock_last)) begin
                w_state_nxt    = w_gnt[PORT_R1] ? OWN_R1 : OWN_R0;
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            end else begin
                w_state_nxt    = OWN_FREE;
                w_lock_cnt_nxt = '0;
            end
        end else if (((r_state == OWN_R0) && !r0_req && !r0_lock) ||
                     ((r_state == OWN_R1) && !r1_req && !r1_lock)) begin
            w_state_nxt    = OWN_FREE;
            w_lock_cnt_nxt = '0;
        end
    end

    assign w_conflict = (r0_req & r1_req & (|w_gnt)) |
                        ((r_state == OWN_R0) & r1_req) |
                        ((r_state == OWN_R1) & r0_req);

    assign w_rd0 = w_gnt[PORT_R0] & ~r0_we;
    assign w_rd1 = w_gnt[PORT_R1] & ~r1_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= OWN_FREE;
            r_last_gnt     <= 1'b1;
            r_lock_cnt     <= '0;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_rdata0       <= '0;
            r_rdata1       <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_rvalid0  <= w_rd0;
            r_rvalid1  <= w_rd1;
            if (w_rd0) r_rdata0 <= mem_spo;
            if (w_rd1) r_rdata1 <= mem_spo;
            if (w_conflict) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign r0_gnt       = w_gnt[PORT_R0];
    assign r1_gnt       = w_gnt[PORT_R1];
    assign mem_a        = w_gnt[PORT_R1] ? r1_addr  : (w_gnt[PORT_R0] ? r0_addr  : '0);
    assign mem_d        = w_gnt[PORT_R1] ? r1_wdata : (w_gnt[PORT_R0] ? r0_wdata : '0);
    assign mem_we       = (w_gnt[PORT_R0] & r0_we) | (w_gnt[PORT_R1] & r1_we);
    assign r0_rvalid    = r_rvalid0;
    assign r1_rvalid    = r_rvalid1;
    assign r0_rdata     = r_rdata0;
    assign r1_rdata     = r_rdata1;
    assign owner        = r_state;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire
